// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the fetch front end.
//   fetch_state_e : fetch FSM state encoding
//   INSTR_W       : architectural instruction width
//   PC_INC        : sequential PC step in bytes
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // one dead cycle after reset, no request
    S_REQ  = 2'd1,  // request presented to imem, waiting for grant
    S_WAIT = 2'd2,  // granted, waiting for the response
    S_HOLD = 2'd3   // instruction buffered, waiting for decode
  } fetch_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

endpackage

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit -- program counter, single-outstanding instruction fetch FSM
// and one-entry instruction buffer feeding decode.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   redirect_i/_pc_i         taken branch/jump and its target (low 2 bits ignored)
//   imem_req_o/_addr_o       fetch request and address (address is always the PC)
//   imem_gnt_i               request accepted when imem_req_o && imem_gnt_i
//   imem_rvalid_i/_rdata_i   fetch response
//   inst_valid_o/_o/_pc_o    buffered instruction and its address to decode
//   inst_ready_i             decode accepts when inst_valid_o && inst_ready_i
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [PC_W-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [PC_W-1:0] inst_o,
  output logic [PC_W-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            inst_valid_q, inst_valid_d;
  logic [PC_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;

  logic [PC_W-1:0] redirect_tgt;
  logic            transfer;
  logic            unused_redirect_lsbs;

  // Targets are forced word aligned; the dropped bits are intentionally unused.
  assign redirect_tgt         = {redirect_pc_i[PC_W-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
  assign transfer             = inst_valid_q & inst_ready_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;

    case (state_q)
      // Redirect is ignored here: nothing has been fetched yet.
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (redirect_i) pc_d = redirect_tgt;
        if (imem_gnt_i) begin
          state_d = S_WAIT;
          // The granted fetch was for the old PC; its response must be dropped.
          kill_d  = redirect_i;
        end
      end

      S_WAIT: begin
        if (redirect_i) pc_d = redirect_tgt;
        if (imem_rvalid_i) begin
          kill_d = 1'b0;
          if (kill_q || redirect_i) begin
            // Stale response: discard and refetch from the (new) PC.
            state_d = S_REQ;
          end else begin
            state_d      = S_HOLD;
            inst_d       = imem_rdata_i;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
          end
        end else if (redirect_i) begin
          kill_d = 1'b1;
        end
      end

      S_HOLD: begin
        // A same-cycle transfer is still delivered; redirect only decides the next PC.
        if (redirect_i) begin
          pc_d         = redirect_tgt;
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end else if (transfer) begin
          pc_d         = pc_q + PC_W'(PC_INC);
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign imem_req_o   = (state_q == S_REQ);
  assign imem_addr_o  = pc_q;
  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit -- directed bench for fetch_pc_unit with a transaction-level
// reference model, an imem responder with programmable latency, and a second
// instance (RESET_PC = 32'hFFFF_FFFC) for the PC wrap case.
module tb_fetch_pc_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, redirect, gnt, rvalid, valid, ready, req;
  logic [31:0] redirect_pc, addr, rdata, inst, inst_pc;

  // Wrap instance signals
  logic        redirect_w, gnt_w, rvalid_w, valid_w, ready_w, req_w;
  logic [31:0] redirect_pc_w, addr_w, rdata_w, inst_w, inst_pc_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .inst_valid_o(valid), .inst_o(inst), .inst_pc_o(inst_pc), .inst_ready_i(ready)
  );

  fetch_pc_unit #(.PC_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk_i(clk), .rst_i(rst), .redirect_i(redirect_w), .redirect_pc_i(redirect_pc_w),
    .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_gnt_i(gnt_w),
    .imem_rvalid_i(rvalid_w), .imem_rdata_i(rdata_w),
    .inst_valid_o(valid_w), .inst_o(inst_w), .inst_pc_o(inst_pc_w), .inst_ready_i(ready_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 4) | 32'h0000_0013;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  // ---------------- imem responder (main DUT) ----------------
  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;
  resp_t       rq[$];
  int          rcyc = 0;
  int          resp_lat = 1;
  bit          gnt_en = 1'b1;
  bit          force_rvalid = 1'b0;
  logic [31:0] salt = 32'h0;

  always @(posedge clk) begin
    resp_t r;
    #2;
    rcyc++;
    rvalid = 1'b0;
    rdata  = 32'hDEAD_BEEF;
    if (rq.size() > 0 && rq[0].due == rcyc) begin
      rvalid = 1'b1;
      rdata  = rq[0].data;
      void'(rq.pop_front());
    end else if (force_rvalid) begin
      rvalid = 1'b1;
      rdata  = 32'hBAD0_0BAD;
    end
    gnt = gnt_en;
    if (req && gnt) begin
      r.data = mem_word(addr) ^ salt;
      r.due  = rcyc + resp_lat;
      rq.push_back(r);
    end
  end

  // Wrap instance: always granted, response one cycle after grant.
  bit w_pend = 1'b0;
  always @(posedge clk) begin
    #2;
    rvalid_w = w_pend;
    rdata_w  = 32'h0000_0093;
    w_pend   = req_w;
  end

  // ---------------- reference model ----------------
  // Abstract view: a fetch is either not started, outstanding (maybe killed),
  // or an instruction is buffered; a request is presented when none of those.
  bit          m_live = 1'b0;
  bit          m_started, m_out, m_kill, m_bv;
  logic [31:0] m_pc, m_bi, m_bpc;
  logic [31:0] grant_q[$], dlv_pc_q[$], dlv_inst_q[$];
  logic [31:0] grant_w_q[$], dlv_w_q[$];

  always @(posedge clk) begin
    logic [31:0] tgt;
    tgt = {redirect_pc[31:2], 2'b00};
    if (!rst) begin
      if (req && gnt) grant_q.push_back(addr);
      if (valid && ready) begin
        dlv_pc_q.push_back(inst_pc);
        dlv_inst_q.push_back(inst);
      end
      if (req_w && gnt_w) grant_w_q.push_back(addr_w);
      if (valid_w && ready_w) dlv_w_q.push_back(inst_pc_w);
    end
    if (rst) begin
      m_live    <= 1'b1;
      m_started <= 1'b0;
      m_out     <= 1'b0;
      m_kill    <= 1'b0;
      m_bv      <= 1'b0;
      m_pc      <= 32'h0;
      m_bi      <= 32'h0;
      m_bpc     <= 32'h0;
    end else if (m_live) begin
      if (!m_started) begin
        m_started <= 1'b1;
      end else if (m_bv) begin
        if (redirect) begin
          m_bv <= 1'b0;
          m_pc <= tgt;
        end else if (ready) begin
          m_bv <= 1'b0;
          m_pc <= m_pc + 32'd4;
        end
      end else if (m_out) begin
        if (rvalid) begin
          m_out  <= 1'b0;
          m_kill <= 1'b0;
          if (!m_kill && !redirect) begin
            m_bv  <= 1'b1;
            m_bi  <= rdata;
            m_bpc <= m_pc;
          end
        end else if (redirect) begin
          m_kill <= 1'b1;
        end
        if (redirect) m_pc <= tgt;
      end else begin
        if (gnt) begin
          m_out  <= 1'b1;
          m_kill <= redirect;
        end
        if (redirect) m_pc <= tgt;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("model_req", {31'b0, req}, {31'b0, m_started && !m_out && !m_bv});
      chk("model_addr", addr, m_pc);
      chk("model_valid", {31'b0, valid}, {31'b0, m_bv});
      if (m_bv) begin
        chk("model_inst", inst, m_bi);
        chk("model_inst_pc", inst_pc, m_bpc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    redirect = 1'b0;
    force_rvalid = 1'b0;
    repeat (n) @(negedge clk);
    grant_q.delete();
    dlv_pc_q.delete();
    dlv_inst_q.delete();
    grant_w_q.delete();
    dlv_w_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_dlv(input int n, input string name);
    int c = 0;
    while (dlv_pc_q.size() < n && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk(name, {31'b0, dlv_pc_q.size() >= n}, 32'd1);
  endtask

  task automatic wait_valid_pc(input logic [31:0] pc, input string name);
    int c = 0;
    while (!(valid && inst_pc == pc) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk(name, {31'b0, valid && inst_pc == pc}, 32'd1);
  endtask

  task automatic wait_grant_of(input logic [31:0] a, input string name);
    int c = 0;
    while (!(req && gnt && addr == a) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk(name, {31'b0, req && gnt && addr == a}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
    redirect_w = 1'b0; redirect_pc_w = 32'h0; gnt_w = 1'b1; ready_w = 1'b1;
    rvalid = 1'b0; rdata = 32'h0; gnt = 1'b1; rvalid_w = 1'b0; rdata_w = 32'h0;

    // T1: reset release and streaming fetch 0,4,8
    resp_lat = 1; gnt_en = 1'b1; ready = 1'b1;
    do_reset(6);
    chk("t1_reset_req", {31'b0, req}, 32'd0);
    chk("t1_reset_valid", {31'b0, valid}, 32'd0);
    chk("t1_reset_inst", inst, 32'h0);
    chk("t1_reset_inst_pc", inst_pc, 32'h0);
    chk("t1_reset_addr", addr, 32'h0);
    @(negedge clk);
    chk("t1_first_req", {31'b0, req}, 32'd1);
    @(negedge clk);
    chk("t1_wait_valid", {31'b0, valid}, 32'd0);
    @(negedge clk);
    chk("t1_latency_valid", {31'b0, valid}, 32'd1);
    chk("t1_latency_inst", inst, 32'h0000_0013);
    wait_dlv(3, "t1_dlv_timeout");
    chk("t1_grant0", qat(grant_q, 0), 32'h0);
    chk("t1_grant1", qat(grant_q, 1), 32'h4);
    chk("t1_grant2", qat(grant_q, 2), 32'h8);
    chk("t1_dlv0", qat(dlv_pc_q, 0), 32'h0);
    chk("t1_dlv1", qat(dlv_pc_q, 1), 32'h4);
    chk("t1_dlv2", qat(dlv_pc_q, 2), 32'h8);
    chk("t1_dlv2_inst", qat(dlv_inst_q, 2), 32'h0000_0093);

    // T2: backpressure with a spurious rvalid while holding
    ready = 1'b0;
    do_reset(6);
    wait_valid_pc(32'h0, "t2_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      force_rvalid = (i == 1);
      chk("t2_hold_valid", {31'b0, valid}, 32'd1);
      chk("t2_hold_inst", inst, 32'h0000_0013);
      chk("t2_hold_pc", inst_pc, 32'h0);
      chk("t2_hold_noreq", {31'b0, req}, 32'd0);
      @(negedge clk);
    end
    force_rvalid = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    chk("t2_next_req", {31'b0, req}, 32'd1);
    chk("t2_next_addr", addr, 32'h4);
    chk("t2_cleared_valid", {31'b0, valid}, 32'd0);
    wait_dlv(2, "t2_dlv_timeout");
    chk("t2_dlv0", qat(dlv_pc_q, 0), 32'h0);
    chk("t2_dlv1", qat(dlv_pc_q, 1), 32'h4);

    // T3: kill in flight (redirect in WAIT for addr 8, rvalid two cycles later)
    resp_lat = 3; ready = 1'b1;
    do_reset(6);
    wait_grant_of(32'h8, "t3_grant8_timeout");
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    wait_dlv(3, "t3_dlv_timeout");
    chk("t3_grant2", qat(grant_q, 2), 32'h8);
    chk("t3_grant3", qat(grant_q, 3), 32'h40);
    chk("t3_dlv1", qat(dlv_pc_q, 1), 32'h4);
    chk("t3_dlv2", qat(dlv_pc_q, 2), 32'h40);
    chk("t3_dlv2_inst", qat(dlv_inst_q, 2), 32'h0000_0413);

    // T4: misaligned redirect with same-cycle transfer in HOLD
    resp_lat = 1; ready = 1'b0;
    do_reset(6);
    wait_valid_pc(32'h0, "t4_v0_timeout");
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    wait_valid_pc(32'h4, "t4_v4_timeout");
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    redirect = 1'b0;
    chk("t4_valid_cleared", {31'b0, valid}, 32'd0);
    chk("t4_req_target", {31'b0, req}, 32'd1);
    chk("t4_addr_target", addr, 32'h100);
    wait_dlv(3, "t4_dlv_timeout");
    chk("t4_dlv1", qat(dlv_pc_q, 1), 32'h4);
    chk("t4_dlv2", qat(dlv_pc_q, 2), 32'h100);
    chk("t4_grant2", qat(grant_q, 2), 32'h100);

    // T5: PC wrap on the RESET_PC = FFFF_FFFC instance
    do_reset(6);
    for (int c = 0; c < 200 && grant_w_q.size() < 2; c++) @(negedge clk);
    chk("t5_grants_timeout", {31'b0, grant_w_q.size() >= 2}, 32'd1);
    chk("t5_grant0", qat(grant_w_q, 0), 32'hFFFF_FFFC);
    chk("t5_grant1", qat(grant_w_q, 1), 32'h0000_0000);
    chk("t5_dlv0", qat(dlv_w_q, 0), 32'hFFFF_FFFC);

    // T6: reset while in WAIT; the stale response lands in IDLE
    resp_lat = 2; ready = 1'b1; salt = 32'h0;
    do_reset(6);
    wait_grant_of(32'h0, "t6_grant_timeout");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    salt = 32'h5A00_0000;
    wait_dlv(1, "t6_dlv_timeout");
    chk("t6_dlv_count", dlv_pc_q.size(), 32'd1);
    chk("t6_dlv_pc", qat(dlv_pc_q, 0), 32'h0);
    chk("t6_dlv_inst", qat(dlv_inst_q, 0), 32'h5A00_0013);
    salt = 32'h0;

    // T7: redirect in IDLE ignored, in REQ without grant, in REQ with grant
    resp_lat = 1; gnt_en = 1'b0; ready = 1'b1;
    do_reset(6);
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    chk("t7_idle_ignored", addr, 32'h0);
    chk("t7_idle_req", {31'b0, req}, 32'd1);
    redirect_pc = 32'h300;
    @(negedge clk);
    chk("t7_req_nognt_addr", addr, 32'h300);
    redirect_pc = 32'h404; gnt_en = 1'b1;
    @(negedge clk);
    chk("t7_req_addr2", addr, 32'h404);
    redirect_pc = 32'h502;
    @(negedge clk);
    redirect = 1'b0;
    chk("t7_wait_addr", addr, 32'h500);
    chk("t7_wait_noreq", {31'b0, req}, 32'd0);
    wait_dlv(1, "t7_dlv_timeout");
    chk("t7_grant0", qat(grant_q, 0), 32'h404);
    chk("t7_grant1", qat(grant_q, 1), 32'h500);
    chk("t7_dlv0", qat(dlv_pc_q, 0), 32'h500);
    chk("t7_dlv_count", dlv_pc_q.size(), 32'd1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
